// File: rtl/video_timing_gen_pkg.sv
// Shared types for the raster timing generator: timing record, axis phases and
// the 640x480@60 default mode.
package video_timing_pkg;

    localparam int TIMING_H_W = 11;
    localparam int TIMING_V_W = 10;

    typedef struct packed {
        logic [TIMING_H_W-1:0] h_vis;
        logic [TIMING_H_W-1:0] h_front;
        logic [TIMING_H_W-1:0] h_sync;
        logic [TIMING_H_W-1:0] h_back;
        logic [TIMING_V_W-1:0] v_vis;
        logic [TIMING_V_W-1:0] v_front;
        logic [TIMING_V_W-1:0] v_sync;
        logic [TIMING_V_W-1:0] v_back;
    } timing_t;

    // One-hot so each phase decode is a single flop bit.
    typedef enum logic [3:0] {
        PH_BACK  = 4'b0001,
        PH_VIS   = 4'b0010,
        PH_FRONT = 4'b0100,
        PH_SYNC  = 4'b1000
    } phase_e;

    localparam timing_t DEF_640x480 = '{
        h_vis: 11'd640, h_front: 11'd16, h_sync: 11'd96, h_back: 11'd48,
        v_vis: 10'd480, v_front: 10'd10, v_sync: 10'd2,  v_back: 10'd33
    };

    function automatic logic timing_ok(input timing_t t);
        return (t.h_vis != '0) && (t.h_front != '0) && (t.h_sync != '0) && (t.h_back != '0) &&
               (t.v_vis != '0) && (t.v_front != '0) && (t.v_sync != '0) && (t.v_back != '0);
    endfunction

endpackage

// File: rtl/video_axis_counter.sv
// One raster axis: walks BACK -> VIS -> FRONT -> SYNC, counting each phase
// length in steps, and flags the step that leaves SYNC.
module video_axis_counter
    import video_timing_pkg::*;
#(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    input  logic [W-1:0] len_back,
    input  logic [W-1:0] len_vis,
    input  logic [W-1:0] len_front,
    input  logic [W-1:0] len_sync,
    output phase_e       phase,
    output logic [W-1:0] count,
    output logic         wrap
);

    phase_e       phase_q, phase_d;
    logic [W-1:0] count_q;
    logic [W-1:0] cur_len;
    logic         last;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        phase_d = phase_q;
        cur_len = len_back;
        unique case (phase_q)
            PH_BACK:  cur_len = len_back;
            PH_VIS:   cur_len = len_vis;
            PH_FRONT: cur_len = len_front;
            PH_SYNC:  cur_len = len_sync;
            default:  cur_len = len_back;
        endcase
        last = (count_q == cur_len - W'(1));
        if (step && last) begin
            unique case (phase_q)
                PH_BACK:  phase_d = PH_VIS;
                PH_VIS:   phase_d = PH_FRONT;
                PH_FRONT: phase_d = PH_SYNC;
                default:  phase_d = PH_BACK;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PH_BACK;
            count_q <= '0;
        end else begin
            phase_q <= phase_d;
            if (step) count_q <= last ? '0 : count_q + W'(1);
        end
    end

    assign phase = phase_q;
    assign count = count_q;
    assign wrap  = step && last && (phase_q == PH_SYNC);

endmodule

// File: rtl/video_timing_gen.sv
// Reprogrammable raster timing generator with pixel enable, frame-boundary
// config shadowing, selectable sync polarity and line/frame strobes.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int      H_W        = TIMING_H_W,
    parameter int      V_W        = TIMING_V_W,
    parameter int      FRAME_W    = 32,
    parameter logic    HSYNC_POL  = 1'b0,
    parameter logic    VSYNC_POL  = 1'b0,
    parameter timing_t DEF_TIMING = DEF_640x480
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_en,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  timing_t            cfg_timing,
    output logic               cfg_err,
    output logic               hsync,
    output logic               vsync,
    output logic               visible,
    output logic [H_W-1:0]     position_x,
    output logic [V_W-1:0]     position_y,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame
);

    timing_t            active_q, shadow_q;
    logic               pending_q, cfg_err_q;
    logic [FRAME_W-1:0] frame_q;
    phase_e             h_phase, v_phase;
    logic [H_W-1:0]     h_count;
    logic [V_W-1:0]     v_count;
    logic               h_wrap, v_wrap;
    logic               cfg_accept, cfg_good;

    video_axis_counter #(.W(H_W)) u_h (
        .clk(clk), .rst(rst), .step(pix_en),
        .len_back(active_q.h_back), .len_vis(active_q.h_vis),
        .len_front(active_q.h_front), .len_sync(active_q.h_sync),
        .phase(h_phase), .count(h_count), .wrap(h_wrap)
    );

    video_axis_counter #(.W(V_W)) u_v (
        .clk(clk), .rst(rst), .step(h_wrap),
        .len_back(active_q.v_back), .len_vis(active_q.v_vis),
        .len_front(active_q.v_front), .len_sync(active_q.v_sync),
        .phase(v_phase), .count(v_count), .wrap(v_wrap)
    );

    assign cfg_accept = cfg_valid && !pending_q;
    assign cfg_good   = timing_ok(cfg_timing);

    // v_wrap is the frame end; a config accepted on that same cycle sets pending
    // after the clear below, so it waits for the following frame end.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q  <= DEF_TIMING;
            pending_q <= 1'b0;
            cfg_err_q <= 1'b0;
            frame_q   <= '0;
        end else begin
            cfg_err_q <= cfg_accept && !cfg_good;
            if (v_wrap) begin
                frame_q   <= frame_q + FRAME_W'(1);
                pending_q <= 1'b0;
                if (pending_q) active_q <= shadow_q;
            end
            if (cfg_accept && cfg_good) pending_q <= 1'b1;
        end
    end

    // NOTE: the shadow has no reset; it is only read while pending_q is set, which reset clears.
    always_ff @(posedge clk) begin
        if (cfg_accept && cfg_good) shadow_q <= cfg_timing;
    end

    assign cfg_ready   = !pending_q;
    assign cfg_err     = cfg_err_q;
    assign frame       = frame_q;
    assign hsync       = (h_phase == PH_SYNC) ? HSYNC_POL : !HSYNC_POL;
    assign vsync       = (v_phase == PH_SYNC) ? VSYNC_POL : !VSYNC_POL;
    assign visible     = (h_phase == PH_VIS) && (v_phase == PH_VIS);
    assign position_x  = visible ? h_count : '0;
    assign position_y  = visible ? v_count : '0;
    assign line_start  = pix_en && (h_phase == PH_VIS) && (h_count == '0);
    assign frame_start = line_start && (v_phase == PH_VIS) && (v_count == '0);

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: a linear-index raster model predicts
// every cycle's outputs, plus hand-counted pulse totals over whole frames.
module tb_video_timing_gen;
    import video_timing_pkg::*;

    localparam timing_t D  = '{h_vis: 11'd6, h_front: 11'd2, h_sync: 11'd3, h_back: 11'd1,
                               v_vis: 10'd4, v_front: 10'd1, v_sync: 10'd2, v_back: 10'd2};
    localparam timing_t T  = '{h_vis: 11'd4, h_front: 11'd1, h_sync: 11'd2, h_back: 11'd1,
                               v_vis: 10'd3, v_front: 10'd1, v_sync: 10'd1, v_back: 10'd1};
    localparam timing_t T2 = '{h_vis: 11'd3, h_front: 11'd1, h_sync: 11'd1, h_back: 11'd1,
                               v_vis: 10'd2, v_front: 10'd1, v_sync: 10'd1, v_back: 10'd1};

    typedef struct packed {
        logic        hsync, vsync, visible;
        logic [10:0] px;
        logic [9:0]  py;
        logic        ls, fs, rdy, err;
        logic [31:0] frame;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst, pix_en, cfg_valid;
    timing_t     cfg_timing;
    logic        cfg_ready, cfg_err, hsync, vsync, visible, line_start, frame_start;
    logic [10:0] position_x;
    logic [9:0]  position_y;
    logic [31:0] frame;

    int n_vec = 0;
    int n_bad = 0;
    int n_hs, n_vis, n_fs, n_ls;
    obs_t sb_q[$];

    timing_t     m_act, m_sh;
    bit          m_pend, m_err;
    int          m_hi, m_vi;
    logic [31:0] m_frame;

    video_timing_gen #(.DEF_TIMING(D)) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_timing(cfg_timing), .cfg_err(cfg_err), .hsync(hsync), .vsync(vsync),
        .visible(visible), .position_x(position_x), .position_y(position_y),
        .line_start(line_start), .frame_start(frame_start), .frame(frame)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int region(input int idx, input int b, input int v, input int f);
        if (idx < b) return 0;
        if (idx < b + v) return 1;
        if (idx < b + v + f) return 2;
        return 3;
    endfunction

    function automatic int htot();
        return int'(m_act.h_back) + int'(m_act.h_vis) + int'(m_act.h_front) + int'(m_act.h_sync);
    endfunction

    function automatic int vtot();
        return int'(m_act.v_back) + int'(m_act.v_vis) + int'(m_act.v_front) + int'(m_act.v_sync);
    endfunction

    function automatic bit m_visible();
        return region(m_hi, m_act.h_back, m_act.h_vis, m_act.h_front) == 1 &&
               region(m_vi, m_act.v_back, m_act.v_vis, m_act.v_front) == 1;
    endfunction

    function automatic obs_t model_out(input bit pe);
        obs_t e;
        int hr, vr;
        hr = region(m_hi, m_act.h_back, m_act.h_vis, m_act.h_front);
        vr = region(m_vi, m_act.v_back, m_act.v_vis, m_act.v_front);
        e.hsync   = (hr != 3);
        e.vsync   = (vr != 3);
        e.visible = (hr == 1) && (vr == 1);
        e.px      = e.visible ? 11'(m_hi - int'(m_act.h_back)) : 11'd0;
        e.py      = e.visible ? 10'(m_vi - int'(m_act.v_back)) : 10'd0;
        e.ls      = pe && (hr == 1) && (m_hi == int'(m_act.h_back));
        e.fs      = e.ls && (vr == 1) && (m_vi == int'(m_act.v_back));
        e.rdy     = !m_pend;
        e.err     = m_err;
        e.frame   = m_frame;
        return e;
    endfunction

    task automatic model_reset();
        m_act = D; m_pend = 0; m_err = 0; m_hi = 0; m_vi = 0; m_frame = '0;
    endtask

    task automatic model_step(input bit pe, input bit cv, input timing_t ct, input bit r);
        bit accept;
        int ht, vt;
        if (r) begin
            model_reset();
            return;
        end
        accept = cv && !m_pend;
        ht = htot();
        vt = vtot();
        if (pe) begin
            if (m_hi == ht - 1) begin
                m_hi = 0;
                if (m_vi == vt - 1) begin
                    m_vi = 0;
                    m_frame++;
                    if (m_pend) m_act = m_sh;
                    m_pend = 0;
                end else m_vi++;
            end else m_hi++;
        end
        if (accept && timing_ok(ct)) begin
            m_sh = ct;
            m_pend = 1;
        end
        m_err = accept && !timing_ok(ct);
    endtask

    // One clock: drive inputs, queue the prediction, tally pulses, advance.
    task automatic cycle(input bit pe, input bit cv, input timing_t ct, input bit r);
        pix_en = pe; cfg_valid = cv; cfg_timing = ct; rst = r;
        sb_q.push_back(model_out(pe));
        #1;
        if (hsync == 1'b0) n_hs++;
        if (visible) n_vis++;
        if (frame_start) n_fs++;
        if (line_start) n_ls++;
        model_step(pe, cv, ct, r);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input bit toggle);
        for (int i = 0; i < n; i++) cycle(toggle ? (i % 2 == 0) : 1'b1, 1'b0, T, 1'b0);
    endtask

    task automatic clear_counts();
        n_hs = 0; n_vis = 0; n_fs = 0; n_ls = 0;
    endtask

    task automatic run_until_loaded();
        int n = 0;
        while (m_pend && n < 400) begin
            run(1, 1'b0);
            n++;
        end
        check("cfg_ready_after_load", int'(cfg_ready), 1);
    endtask

    always @(negedge clk) begin
        obs_t a, e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            a = '{hsync, vsync, visible, position_x, position_y, line_start, frame_start,
                  cfg_ready, cfg_err, frame};
            n_vec++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL outputs @%0t: got hs%b vs%b vis%b x%0d y%0d ls%b fs%b rdy%b err%b fr%0d, expected hs%b vs%b vis%b x%0d y%0d ls%b fs%b rdy%b err%b fr%0d",
                         $time, a.hsync, a.vsync, a.visible, a.px, a.py, a.ls, a.fs, a.rdy, a.err, a.frame,
                         e.hsync, e.vsync, e.visible, e.px, e.py, e.ls, e.fs, e.rdy, e.err, e.frame);
            end
        end
    end

    initial begin
        timing_t bad;
        int n;
        rst = 1'b1; pix_en = 1'b0; cfg_valid = 1'b0; cfg_timing = T;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Default mode, two frames of 108 clocks.
        clear_counts();
        run(216, 1'b0);
        check("def_hsync_clks", n_hs, 54);
        check("def_visible_clks", n_vis, 48);
        check("def_frame_start", n_fs, 2);
        check("def_line_start", n_ls, 18);
        check("def_frame_count", int'(frame), 2);

        // Mid-frame config: old timing to frame end, then T.
        run(30, 1'b0);
        cycle(1'b1, 1'b1, T, 1'b0);
        check("cfg_ready_drop", int'(cfg_ready), 0);
        run_until_loaded();
        clear_counts();
        run(96, 1'b0);
        check("t_hsync_clks", n_hs, 24);
        check("t_visible_clks", n_vis, 24);
        check("t_frame_start", n_fs, 2);
        check("t_line_start", n_ls, 12);

        // pix_en 1,0,1,0: periods double, strobe counts unchanged.
        clear_counts();
        run(192, 1'b1);
        check("half_hsync_clks", n_hs, 48);
        check("half_visible_clks", n_vis, 48);
        check("half_frame_start", n_fs, 2);
        check("half_line_start", n_ls, 12);

        // Zero-length field is rejected, timing unchanged.
        bad = T;
        bad.h_sync = '0;
        cycle(1'b1, 1'b1, bad, 1'b0);
        check("bad_cfg_ready", int'(cfg_ready), 1);
        check("bad_cfg_err", int'(cfg_err), 1);
        clear_counts();
        run(96, 1'b0);
        check("bad_visible_clks", n_vis, 24);

        // Accept on the frame-end cycle waits a full extra frame.
        n = 0;
        while (!(m_hi == htot() - 1 && m_vi == vtot() - 1) && n < 200) begin
            run(1, 1'b0);
            n++;
        end
        cycle(1'b1, 1'b1, T2, 1'b0);
        run(40, 1'b0);
        check("coincide_still_pending", int'(cfg_ready), 0);
        run_until_loaded();
        clear_counts();
        run(60, 1'b0);
        check("t2_visible_clks", n_vis, 12);
        check("t2_frame_start", n_fs, 2);

        // Reset mid-visible with a config pending.
        cycle(1'b1, 1'b1, T, 1'b0);
        n = 0;
        while (!m_visible() && n < 200) begin
            run(1, 1'b0);
            n++;
        end
        cycle(1'b1, 1'b1, T2, 1'b1);
        check("rst_frame", int'(frame), 0);
        check("rst_cfg_ready", int'(cfg_ready), 1);
        clear_counts();
        run(108, 1'b0);
        check("rst_def_visible_clks", n_vis, 24);
        check("rst_def_frame", int'(frame), 1);

        pix_en = 1'b0; cfg_valid = 1'b0;
        n = 0;
        while (sb_q.size() > 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        #1;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
